i2c_target_responder: RTL
=========================

// Module: i2c_target_responder
// PURPOSE
// Synthesizable I2C target (responder) for the far end of the I2CMB controller's bus, replacing the behavioural
// slave model in gate-level and emulation runs. Oversamples SCL/SDA on the system clock, decodes
// START/STOP/address/data, ACKs its own address and serves an internal byte memory with an auto-incrementing pointer.
// PARAMETERS
// TARGET_ADDR  7'h22  7-bit bus address this block answers to
// MEM_DEPTH    32     byte memory entries; power of two, 2..256
// FILT_LEN     3      consecutive equal samples needed to accept an SCL/SDA level change
// PORTS
// clk           in   1   system clock, >= 20x SCL frequency
// rst           in   1   synchronous, active-high reset
// scl_i         in   1   bus SCL level (async)
// sda_i         in   1   bus SDA level (async)
// sda_pull_o    out  1   1 = pull SDA low (open-drain enable); 0 = release
// busy_o        out  1   1 from accepted START until STOP/ignore
// xfer_done_o   out  1   one-cycle pulse on STOP ending an addressed transaction
// xfer_rd_o     out  1   R/W bit of last addressed transaction (1 = read)
// byte_cnt_o    out  8   data bytes moved in current/last transaction (excl. address/pointer bytes), saturates at 255
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, pointer=0, filters preset to 1 (bus idle); memory contents not reset.
// - Input path: 2-flop synchronizer then FILT_LEN-sample filter per line; edges/conditions use filtered levels only.
// - START: SDA 1->0 while SCL=1; STOP: SDA 0->1 while SCL=1. Valid in every state (repeated START included).
// - Bits sampled on filtered SCL rising edge; SDA driven only after SCL falling edge (never changed while SCL=1).
// - FSM: IDLE -> ADDR (8 bits, MSB first) -> ADDR_ACK -> {PTR | RD_DATA}; PTR -> PTR_ACK -> WR_DATA <-> WR_ACK;
//   RD_DATA -> RD_ACK -> {RD_DATA | IGNORE}; address mismatch -> IGNORE; IGNORE waits for START/STOP.
// - Address match (bits[7:1]==TARGET_ADDR): sda_pull_o=1 from 8th SCL falling edge to 9th SCL falling edge.
//   Mismatch: no ACK, sda_pull_o stays 0.
// - Write (R/W=0): first data byte loads pointer (modulo MEM_DEPTH) and is ACKed; each later byte written to
//   mem[ptr], ptr+1 wrapping MEM_DEPTH-1 -> 0, ACKed, byte_cnt_o+1. Write commits on 8th rising edge.
// - Read (R/W=1): mem[ptr] driven MSB first from the ACK's 9th falling edge; sda_pull_o = ~bit.
//   Released on 8th falling edge; controller ACK (SDA=0) on 9th rising edge -> ptr+1, load next byte, byte_cnt_o+1;
//   NACK -> ptr+1, byte_cnt_o+1, IGNORE (SDA released until STOP/START).
// - Repeated START: pointer kept (enables write-pointer-then-read), byte_cnt_o cleared, xfer_done_o not pulsed.
// - START/STOP mid-byte: byte discarded (no mem write, no count), sda_pull_o released within 1 clk, FSM to ADDR/IDLE.
// - STOP: busy_o->0 next clk; xfer_done_o pulses only if an address was ACKed since the last START.
// - rst mid-transaction: immediate return to reset state; SDA released same cycle rst sampled.
// - General call (addr 0) ignored. No clock stretching: scl never driven.
// TESTING
// - Write 0x22/W, ptr 0x05, data A5,3C, STOP -> 3 ACKs (addr,ptr,data0) + ACK data1; mem[5]=A5, mem[6]=3C; byte_cnt_o=2, xfer_done_o 1 pulse, xfer_rd_o=0.
// - Write ptr 0x05, rep-START 0x22/R, read 2 bytes ACK,NACK, STOP -> SDA bytes A5,3C; byte_cnt_o=2; xfer_rd_o=1; ptr ends 7.
// - Address 0x23/W with data -> sda_pull_o never asserted, no mem change, no xfer_done_o pulse.
// - Write ptr 0x1F (MEM_DEPTH=32), data 11,22 -> mem[31]=11, mem[0]=22 (wrap).
// - STOP after 4 bits of data byte -> no write, busy_o=0, sda_pull_o=0; 1-clk SDA glitch (FILT_LEN=3) -> no START detected.
// - Assert rst while driving a read bit low -> sda_pull_o=0 next clk, busy_o=0, next addressed write behaves normally.

Source files
------------

// File: rtl/i2c_target_responder.sv
// I2C target (responder): oversamples SCL/SDA on the system clock, decodes
// START/STOP, address and data bytes, ACKs its own address and serves a byte
// memory through an auto-incrementing pointer. Never drives SCL.
module i2c_target_responder #(
  parameter logic [6:0] TARGET_ADDR = 7'h22,
  parameter int         MEM_DEPTH   = 32,
  parameter int         FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_pull_o,
  output logic       busy_o,
  output logic       xfer_done_o,
  output logic       xfer_rd_o,
  output logic [7:0] byte_cnt_o
);

  localparam int PTR_W  = $clog2(MEM_DEPTH);
  localparam int FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILT_LEN - 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
  } state_t;

  state_t state_q, state_d;

  // Index 0 carries SCL, index 1 carries SDA through the input path.
  logic [1:0]        sync1_q, sync2_q, filt_q, filt_d1_q;
  logic [FCNT_W-1:0] fcnt_q [2];

  logic [3:0]       bit_cnt_q;
  logic [7:0]       shreg_q;
  logic [PTR_W-1:0] ptr_q;
  logic [7:0]       cnt_q;
  logic             pull_q, done_q, rd_q, acked_q;
  logic [7:0]       mem [MEM_DEPTH];

  logic pull_d, done_d;
  logic shift_en, rd_shift, rd_load, bit_clr, bit_inc, bit_mark;
  logic ptr_load, ptr_inc, mem_we, cnt_clr, cnt_inc, addr_ok;

  logic scl_rise, scl_fall, start_det, stop_det, addr_match;
  logic [7:0] rx_byte, rd_byte;

  // Synchronize both lines, then accept a new level only after FILT_LEN
  // consecutive samples disagree with the current filtered level.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      filt_q    <= 2'b11;
      filt_d1_q <= 2'b11;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
    end else begin
      sync1_q   <= {sda_i, scl_i};
      sync2_q   <= sync1_q;
      filt_d1_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FCNT_MAX) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FCNT_ONE;
        end
      end
    end
  end

  assign scl_rise   = filt_q[0] & ~filt_d1_q[0];
  assign scl_fall   = ~filt_q[0] & filt_d1_q[0];
  assign start_det  = filt_q[0] & filt_d1_q[0] & filt_d1_q[1] & ~filt_q[1];
  assign stop_det   = filt_q[0] & filt_d1_q[0] & ~filt_d1_q[1] & filt_q[1];
  assign rx_byte    = {shreg_q[6:0], filt_q[1]};
  assign rd_byte    = mem[ptr_q];
  assign addr_match = (shreg_q[7:1] == TARGET_ADDR) && (shreg_q[7:1] != 7'd0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath strobes; START/STOP override any byte in flight.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d  = state_q;
    pull_d   = pull_q;
    done_d   = 1'b0;
    shift_en = 1'b0;
    rd_shift = 1'b0;
    rd_load  = 1'b0;
    bit_clr  = 1'b0;
    bit_inc  = 1'b0;
    bit_mark = 1'b0;
    ptr_load = 1'b0;
    ptr_inc  = 1'b0;
    mem_we   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    addr_ok  = 1'b0;
    if (start_det) begin
      state_d = ST_ADDR;
      pull_d  = 1'b0;
      bit_clr = 1'b1;
      cnt_clr = 1'b1;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      pull_d  = 1'b0;
      done_d  = acked_q;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_en = 1'b1;
            bit_inc  = 1'b1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (addr_match) begin
              addr_ok = 1'b1;
              pull_d  = 1'b1;
              state_d = ST_ADDR_ACK;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_clr = 1'b1;
            if (rd_q) begin
              rd_load = 1'b1;
              pull_d  = ~rd_byte[7];
              state_d = ST_RD_DATA;
            end else begin
              pull_d  = 1'b0;
              state_d = ST_PTR;
            end
          end
        end
        ST_PTR, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_en = 1'b1;
            bit_inc  = 1'b1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == ST_PTR) begin
                ptr_load = 1'b1;
              end else begin
                mem_we  = 1'b1;
                ptr_inc = 1'b1;
                cnt_inc = 1'b1;
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            pull_d  = 1'b1;
            state_d = (state_q == ST_PTR) ? ST_PTR_ACK : ST_WR_ACK;
          end
        end
        ST_PTR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            pull_d  = 1'b0;
            bit_clr = 1'b1;
            state_d = ST_WR_DATA;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_inc = 1'b1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              pull_d  = 1'b0;
              state_d = ST_RD_ACK;
            end else begin
              rd_shift = 1'b1;
              pull_d   = ~shreg_q[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            ptr_inc = 1'b1;
            cnt_inc = 1'b1;
            if (filt_q[1]) state_d = ST_IGNORE;
            else           bit_mark = 1'b1;
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            rd_load = 1'b1;
            bit_clr = 1'b1;
            pull_d  = ~rd_byte[7];
            state_d = ST_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers driven by the FSM strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      pull_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= 1'b0;
      acked_q   <= 1'b0;
    end else begin
      pull_q <= pull_d;
      done_q <= done_d;
      if (bit_clr)       bit_cnt_q <= '0;
      else if (bit_mark) bit_cnt_q <= 4'd9;
      else if (bit_inc)  bit_cnt_q <= bit_cnt_q + 4'd1;
      if (rd_load)       shreg_q <= rd_byte;
      else if (shift_en) shreg_q <= rx_byte;
      else if (rd_shift) shreg_q <= {shreg_q[6:0], 1'b0};
      if (ptr_load)      ptr_q <= rx_byte[PTR_W-1:0];
      else if (ptr_inc)  ptr_q <= ptr_q + PTR_ONE;
      if (cnt_clr)                        cnt_q <= '0;
      else if (cnt_inc && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      if (addr_ok) begin
        rd_q    <= shreg_q[0];
        acked_q <= 1'b1;
      end else if (start_det || stop_det) begin
        acked_q <= 1'b0;
      end
    end
  end

  // Byte memory write port; a byte commits on its 8th SCL rising edge.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; its contents are only meaningful once written.
    if (mem_we && !rst) mem[ptr_q] <= rx_byte;
  end

  // Gating with rst releases SDA in the very cycle reset is sampled.
  assign sda_pull_o  = pull_q & ~rst;
  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_IGNORE);
  assign xfer_done_o = done_q;
  assign xfer_rd_o   = rd_q;
  assign byte_cnt_o  = cnt_q;

endmodule
